// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI master arbiter.
// Timeout logic is built only when SPI_ARB_TIMEOUT_EN is defined.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_RESP
  } state_t;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_LEN_W   = 5;
  localparam int DEF_CS_W    = 1;
  localparam int DEF_TIMEOUT = 4096;

endpackage

// File: rtl/spi_arb_rr.sv
// Round-robin winner select: first valid requester at or after ptr,
// wrapping to index 0.
module spi_arb_rr #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic             any
);

  logic found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    any   = |req;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j] && (j >= int'(ptr))) begin
        win[j] = 1'b1;
        found  = 1'b1;
      end
    end
    // wrap-around pass
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j] && (j < int'(ptr))) begin
        win[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Arbitrates NREQ requesters onto one SPI master core.
// Define SPI_ARB_TIMEOUT_EN to enable the BUSY timeout/abort path.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int LEN_W          = DEF_LEN_W,
  parameter int CS_W           = DEF_CS_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ*LEN_W-1:0]  req_len,
  input  logic [NREQ*CS_W-1:0]   req_cs,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic                   m_start,
  output logic [DATA_W-1:0]      m_mosi,
  output logic [LEN_W-1:0]       m_len,
  output logic [CS_W-1:0]        m_cs,
  input  logic                   m_idle,
  input  logic                   m_done,
  input  logic [DATA_W-1:0]      m_miso,
  output logic                   m_abort,
  output logic [NREQ-1:0]        grant,
  output logic                   busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_q;
  logic [PTR_W-1:0]   win_idx, rr_nxt;
  logic [NREQ-1:0]    win, grant_q;
  logic               any;
  logic [DATA_W-1:0]  sel_data, mosi_q, rdata_q;
  logic [LEN_W-1:0]   sel_len, len_q;
  logic [CS_W-1:0]    sel_cs, cs_q;
  logic [NREQ-1:0]    ready_c, rvalid_c;
  logic               start_c, abort_c, tmo_hit;
  logic               accept;

  spi_arb_rr #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_q),
    .win (win),
    .any (any)
  );

  always_comb begin
    win_idx  = '0;
    sel_data = '0;
    sel_len  = '0;
    sel_cs   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (win[j]) begin
        win_idx  = PTR_W'(j);
        sel_data = req_data[j*DATA_W +: DATA_W];
        sel_len  = req_len[j*LEN_W +: LEN_W];
        sel_cs   = req_cs[j*CS_W +: CS_W];
      end
    end
    rr_nxt = (win_idx == PTR_W'(NREQ - 1)) ? '0
           : win_idx + PTR_W'(1);
  end

  assign accept = |(rsp_ready & grant_q);

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_q;
  logic             err_q;

  assign tmo_hit = (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tmo_q <= '0;
    end else if (state_q == S_START) begin
      tmo_q <= '0;
    end else if (state_q == S_BUSY) begin
      tmo_q <= tmo_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_q <= 1'b0;
    end else if (state_q == S_BUSY) begin
      if (m_done) err_q <= 1'b0;
      else if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign rsp_err = sys_rst ? 1'b0 : err_q;
  assign m_abort = sys_rst ? 1'b0 : abort_c;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign tmo_hit    = 1'b0;
  assign rsp_err    = 1'b0;
  assign m_abort    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ready_c  = '0;
    rvalid_c = '0;
    start_c  = 1'b0;
    abort_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any) begin
          ready_c = win;
          state_d = S_START;
        end
      end
      S_START: begin
        if (m_idle) begin
          start_c = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (m_done) begin
          state_d = S_RESP;
        end else if (tmo_hit) begin
          abort_c = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rvalid_c = grant_q;
        if (accept) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      mosi_q  <= '0;
      len_q   <= '0;
      cs_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && any) begin
        grant_q <= win;
        rr_q    <= rr_nxt;
        mosi_q  <= sel_data;
        len_q   <= sel_len;
        cs_q    <= sel_cs;
      end
      if (state_q == S_BUSY) begin
        if (m_done) rdata_q <= m_miso;
        else if (tmo_hit) rdata_q <= '0;
      end
      if (state_q == S_RESP && accept) grant_q <= '0;
    end
  end

  // outputs are forced low for as long as reset is held
  assign req_ready = sys_rst ? '0 : ready_c;
  assign rsp_valid = sys_rst ? '0 : rvalid_c;
  assign rsp_data  = sys_rst ? '0 : rdata_q;
  assign m_start   = sys_rst ? 1'b0 : start_c;
  assign m_mosi    = sys_rst ? '0 : mosi_q;
  assign m_len     = sys_rst ? '0 : len_q;
  assign m_cs      = sys_rst ? '0 : cs_q;
  assign grant     = sys_rst ? '0 : grant_q;
  assign busy      = !sys_rst && (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed self-checking bench for spi_master_arbiter.
// Honours SPI_ARB_TIMEOUT_EN for the timeout scenario.
module tb_spi_master_arbiter;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] req_data;
  logic [9:0]  req_len;
  logic [1:0]  req_cs;
  logic [1:0]  rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err, m_start, m_idle, m_done, m_abort, busy;
  logic [15:0] m_mosi, m_miso;
  logic [4:0]  m_len;
  logic [0:0]  m_cs;
  logic [1:0]  grant;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_master_arbiter #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .sys_clk   (clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_len   (req_len),
    .req_cs    (req_cs),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .m_start   (m_start),
    .m_mosi    (m_mosi),
    .m_len     (m_len),
    .m_cs      (m_cs),
    .m_idle    (m_idle),
    .m_done    (m_done),
    .m_miso    (m_miso),
    .m_abort   (m_abort),
    .grant     (grant),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_busy(input int k, input logic [15:0] d);
    int n;
    req_valid = 2'b00;
    req_valid[k] = 1'b1;
    req_data[k*16 +: 16] = d;
    req_len[k*5 +: 5] = 5'd15;
    req_cs[k] = 1'b1;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    if (req_ready == 2'b00) begin
      n_cmp++; n_bad++;
      $display("FAIL go_busy_grant: req_ready=%b never asserted", req_ready);
    end
    tick();
    req_valid = 2'b00;
    #1;
    n = 0;
    while (!m_start && n < 40) begin
      tick();
      n++;
    end
    if (!m_start) begin
      n_cmp++; n_bad++;
      $display("FAIL go_busy_start: m_start=%b never pulsed", m_start);
    end
    tick();
  endtask

  task automatic finish_txn(input logic [15:0] miso);
    m_done = 1'b1;
    m_miso = miso;
    tick();
    m_done = 1'b0;
    rsp_ready = 2'b11;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    req_valid = 2'b11;
    m_done = 1'b1;
    tick();
    n_cmp++;
    if ({req_ready, rsp_valid, grant, busy, m_start, m_abort, rsp_err,
         rsp_data, m_mosi, m_len, m_cs} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rr=%b rv=%b g=%b busy=%b st=%b mosi=%h want all 0",
               req_ready, rsp_valid, grant, busy, m_start, m_mosi);
    end
    req_valid = 2'b00;
    m_done = 1'b0;
    tick();
    sys_rst = 1'b0;
    tick();
    n_cmp++;
    if ({busy, grant, m_mosi, rsp_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_release: busy=%b grant=%b mosi=%h rdata=%h want 0",
               busy, grant, m_mosi, rsp_data);
    end
  endtask

  task automatic test_single();
    req_data = 32'h0000_aa55;
    req_len = {5'd0, 5'd15};
    req_cs = 2'b01;
    req_valid = 2'b01;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_bad++;
      $display("FAIL single_ready: got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    #1;
    n_cmp++;
    if ({m_start, req_ready, grant} !== {1'b1, 2'b00, 2'b01}) begin
      n_bad++;
      $display("FAIL single_start: m_start=%b ready=%b grant=%b want 1/00/01",
               m_start, req_ready, grant);
    end
    n_cmp++;
    if ({m_mosi, m_len, m_cs} !== {16'haa55, 5'd15, 1'b1}) begin
      n_bad++;
      $display("FAIL single_fields: mosi=%h len=%0d cs=%b want aa55/15/1",
               m_mosi, m_len, m_cs);
    end
    tick();
    n_cmp++;
    if ({m_start, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL single_busy: m_start=%b busy=%b want 0/1", m_start, busy);
    end
    m_done = 1'b1;
    m_miso = 16'h1234;
    tick();
    m_done = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_data, rsp_err} !== {2'b01, 16'h1234, 1'b0}) begin
      n_bad++;
      $display("FAIL single_rsp: rv=%b data=%h err=%b want 01/1234/0",
               rsp_valid, rsp_data, rsp_err);
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    n_cmp++;
    if ({busy, grant, rsp_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL single_idle: busy=%b grant=%b rv=%b want 0",
               busy, grant, rsp_valid);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    int n;
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    req_data = {16'h2222, 16'h1111};
    req_len = {5'd7, 5'd15};
    req_cs = 2'b11;
    req_valid = 2'b11;
    #1;
    for (int t = 0; t < 4; t++) begin
      exp = (t % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin
        tick();
        n++;
      end
      n_cmp++;
      if (req_ready !== exp) begin
        n_bad++;
        $display("FAIL contention_order%0d: ready=%b want %b", t, req_ready, exp);
      end
      tick();
      n_cmp++;
      if ({grant, m_mosi} !== {exp, (exp == 2'b01) ? 16'h1111 : 16'h2222}) begin
        n_bad++;
        $display("FAIL contention_owner%0d: grant=%b mosi=%h want %b", t, grant, m_mosi, exp);
      end
      tick();
      finish_txn(16'(t));
    end
    req_valid = 2'b00;
  endtask

  task automatic test_master_busy();
    m_idle = 1'b0;
    req_valid = 2'b01;
    req_data[15:0] = 16'h0f0f;
    #1;
    tick();
    req_valid = 2'b00;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++;
      if ({m_start, busy} !== 2'b01) begin
        n_bad++;
        $display("FAIL mbusy_hold%0d: m_start=%b busy=%b want 0/1", c, m_start, busy);
      end
      tick();
    end
    m_idle = 1'b1;
    #1;
    n_cmp++;
    if (m_start !== 1'b1) begin
      n_bad++;
      $display("FAIL mbusy_release: m_start=%b want 1", m_start);
    end
    tick();
    n_cmp++;
    if ({m_start, m_mosi} !== {1'b0, 16'h0f0f}) begin
      n_bad++;
      $display("FAIL mbusy_single_pulse: m_start=%b mosi=%h want 0/0f0f", m_start, m_mosi);
    end
    finish_txn(16'h5a5a);
  endtask

  task automatic test_backpressure();
    go_busy(0, 16'hc3c3);
    m_done = 1'b1;
    m_miso = 16'hbeef;
    tick();
    m_done = 1'b0;
    req_data[31:16] = 16'h7777;
    req_valid = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if ({rsp_valid, rsp_data, req_ready} !== {2'b01, 16'hbeef, 2'b00}) begin
        n_bad++;
        $display("FAIL bp_hold%0d: rv=%b data=%h ready=%b want 01/beef/00",
                 c, rsp_valid, rsp_data, req_ready);
      end
      tick();
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid} !== {2'b10, 2'b00}) begin
      n_bad++;
      $display("FAIL bp_next_grant: ready=%b rv=%b want 10/00", req_ready, rsp_valid);
    end
    tick();
    req_valid = 2'b00;
    tick();
    finish_txn(16'h0000);
  endtask

  task automatic test_timeout();
    go_busy(1, 16'h3333);
`ifdef SPI_ARB_TIMEOUT_EN
    for (int c = 1; c < 16; c++) begin
      n_cmp++;
      if (m_abort !== 1'b0) begin
        n_bad++;
        $display("FAIL tmo_early%0d: m_abort=%b want 0", c, m_abort);
      end
      tick();
    end
    n_cmp++;
    if ({m_abort, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL tmo_abort: m_abort=%b busy=%b want 1/1", m_abort, busy);
    end
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_data, m_abort} !== {2'b10, 1'b1, 16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL tmo_rsp: rv=%b err=%b data=%h abort=%b want 10/1/0000/0",
               rsp_valid, rsp_err, rsp_data, m_abort);
    end
    rsp_ready = 2'b11;
    tick();
    rsp_ready = 2'b00;
`else
    repeat (100) tick();
    n_cmp++;
    if ({busy, rsp_valid, m_abort, rsp_err} !== {1'b1, 2'b00, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL tmo_off_wait: busy=%b rv=%b abort=%b err=%b want 1/00/0/0",
               busy, rsp_valid, m_abort, rsp_err);
    end
    finish_txn(16'h4444);
`endif
  endtask

  task automatic test_reset_busy();
    go_busy(0, 16'h9999);
    sys_rst = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, grant, busy, m_start, m_abort, rsp_err,
         rsp_data, m_mosi, m_len, m_cs} !== '0) begin
      n_bad++;
      $display("FAIL rbusy_outputs: g=%b busy=%b mosi=%h want all 0", grant, busy, m_mosi);
    end
    tick();
    sys_rst = 1'b0;
    m_done = 1'b1;
    m_miso = 16'hdead;
    tick();
    m_done = 1'b0;
    n_cmp++;
    if ({busy, rsp_valid, grant, rsp_data} !== '0) begin
      n_bad++;
      $display("FAIL rbusy_late_done: busy=%b rv=%b g=%b data=%h want 0",
               busy, rsp_valid, grant, rsp_data);
    end
    req_data[31:16] = 16'h5151;
    req_valid = 2'b10;
    #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_bad++;
      $display("FAIL rbusy_regrant: ready=%b want 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    n_cmp++;
    if ({grant, m_mosi} !== {2'b10, 16'h5151}) begin
      n_bad++;
      $display("FAIL rbusy_owner: grant=%b mosi=%h want 10/5151", grant, m_mosi);
    end
    tick();
    finish_txn(16'h0101);
  endtask

  initial begin
    sys_rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_len = '0;
    req_cs = '0;
    rsp_ready = '0;
    m_idle = 1'b1;
    m_done = 1'b0;
    m_miso = '0;
    test_reset();
    test_single();
    test_contention();
    test_master_busy();
    test_backpressure();
    test_timeout();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master_arbiter.md
SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 Params: NREQ, default 2, number of requesters (index 0 = host register path, 1 = auto-poll engine); DATA_W, default 16, SPI word width; LEN_W, default 5, length field width; CS_W, default 1, chip-select width; TIMEOUT_CYCLES, default 4096.
REQ-002 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-003 sys_rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  NREQ  per-requester transfer request.
REQ-005 req_ready  out  NREQ  one-hot accept pulse; the transfer is taken when valid&ready.
REQ-006 req_data  in  NREQ*DATA_W  MOSI word per requester, flattened, requester k at [k*DATA_W +: DATA_W].
REQ-007 req_len  in  NREQ*LEN_W  bit count minus 1 per requester (15 = 16 bits).
REQ-008 req_cs  in  NREQ*CS_W  chip-select mask per requester.
REQ-009 rsp_valid  out  NREQ  one-hot response valid toward the owning requester.
REQ-010 rsp_ready  in  NREQ  response accept.
REQ-011 rsp_data  out  DATA_W  MISO word, shared; valid while any rsp_valid bit is high.
REQ-012 rsp_err  out  1  response flag: transfer timed out.
REQ-013 m_start  out  1  one-cycle start pulse to the SPI master core.
REQ-014 m_mosi / m_len / m_cs  out  DATA_W / LEN_W / CS_W  latched transfer fields, stable from START until return to IDLE.
REQ-015 m_idle  in  1  master idle; m_done  in  1  one-cycle pulse, with m_miso valid in the same cycle.
REQ-016 m_miso  in  DATA_W  received word.
REQ-017 m_abort  out  1  one-cycle abort pulse to the master.
REQ-018 grant  out  NREQ  one-hot current owner, all zero in IDLE; busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, START, BUSY and RESP.
REQ-020 IDLE: if any req_valid is high, pick a winner round-robin starting at pointer rr; in the same cycle pulse req_ready[winner], latch that requester's data/len/cs, set grant, set rr = winner+1 mod NREQ, and go to START.
REQ-021 START: when m_idle=1, pulse m_start for exactly one cycle and go to BUSY; if m_idle=0, hold in START.
REQ-022 BUSY: on m_done, latch m_miso into rsp_data, clear rsp_err, and go to RESP.
REQ-023 RESP: hold rsp_valid[owner] and rsp_data stable until rsp_ready[owner]=1; then clear grant and go to IDLE; the next grant comes no earlier than the following cycle.
REQ-024 Grant-to-m_start latency SHALL be 1 cycle when m_idle=1.
REQ-025 A requester dropping req_valid before it is granted SHALL lose no state and receive no response; requests that are not granted are not buffered.
REQ-026 With two requesters continuously valid, grants SHALL alternate; no requester waits more than NREQ-1 transactions.
REQ-027 An m_done seen outside BUSY SHALL be ignored.
REQ-028 At most one transaction is outstanding; req_ready SHALL be 0 in every non-IDLE state.

Reset
REQ-029 sys_rst SHALL force IDLE, rr=0 and registered rsp_data/m_mosi/m_len/m_cs=0; while sys_rst is high, every output SHALL be 0; any transfer in flight is abandoned with no response.

Configuration
REQ-030 With SPI_ARB_TIMEOUT_EN defined: a counter clears on BUSY entry; if TIMEOUT_CYCLES elapse without m_done, the block pulses m_abort, sets rsp_data=0 and rsp_err=1, and goes to RESP.
REQ-031 Without SPI_ARB_TIMEOUT_EN: there is no counter, m_abort and rsp_err are tied 0, and BUSY waits indefinitely.

Structure
REQ-032 Package spi_arb_pkg SHALL hold the state enum, the DATA_W/LEN_W/CS_W defaults and the default TIMEOUT_CYCLES.
REQ-033 Round-robin selection SHALL be sub-module spi_arb_rr (inputs req vector and rr pointer; outputs one-hot winner and any-valid).

Verification
REQ-034 Single: req_valid=01, data 16'haa55, len 15, cs 1 -> req_ready=01 one cycle, m_start 1 cycle later, m_mosi=16'haa55; m_done with m_miso 16'h1234 -> rsp_valid=01, rsp_data=16'h1234, rsp_err=0.
REQ-035 Contention: req_valid=11 from reset, both held -> grant order 0,1,0,1 over four transactions.
REQ-036 Master busy: m_idle=0 for 10 cycles after grant -> no m_start until the cycle m_idle returns to 1.
REQ-037 Response backpressure: rsp_ready low for 5 cycles -> rsp_valid and rsp_data held, no new grant; a grant is allowed the cycle after accept.
REQ-038 Timeout (macro on, TIMEOUT_CYCLES=16): no m_done -> m_abort pulses at cycle 16 of BUSY, rsp_err=1, rsp_data=0; with the macro off -> still in BUSY after 100 cycles.
REQ-039 Reset mid-BUSY: sys_rst high for 1 cycle -> IDLE, all outputs 0; a late m_done is ignored; the next req_valid=10 is granted to requester 1.
